// File: rtl/exception_sequencer.sv
// exception_sequencer
// Multicycle sequencer that carries the CPU from exception detection to
// handler entry: it latches the cause and the faulting PC, writes EPC,
// steers the memory-address mux to the handler vector (253/254/255),
// waits for the memory read and finally loads PC with the handler byte.
// The main control unit stalls while busy is high.
//
// Optional feature: define EXC_COUNT_EN to add the 8-bit saturating
// exc_count output counting completed sequences.

module exception_sequencer #(
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned PC_OFFSET = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        invalid_op,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic [31:0] pc_current,
    input  logic [31:0] mem_data_out,
    output logic [2:0]  mem_addr_sel,
    output logic        epc_write,
    output logic [31:0] epc_value,
    output logic        pc_write,
    output logic [31:0] pc_value,
    output logic        busy,
    output logic        exc_done,
    output logic [1:0]  exc_cause
`ifdef EXC_COUNT_EN
    ,
    output logic [7:0]  exc_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE_EPC = 2'd1,
        MEM_READ = 2'd2,
        LOAD_PC  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;
    localparam logic [1:0] CAUSE_DIVZERO = 2'b11;

    state_t      state;
    state_t      state_next;
    logic [1:0]  flag_cause;
    logic        take_exc;
    logic        mem_read_last;
    logic [2:0]  wait_cnt;
    logic        unused_mem_hi;

    // Only the low byte of the vector read forms the handler address.
    assign unused_mem_hi = ^mem_data_out[31:8];

    // Fixed-priority encode of the fault flags: invalid_op > overflow > div_zero.
    always_comb begin
        flag_cause = CAUSE_NONE;
        if (invalid_op) begin
            flag_cause = CAUSE_INVALID;
        end else if (overflow) begin
            flag_cause = CAUSE_OVF;
        end else if (div_zero) begin
            flag_cause = CAUSE_DIVZERO;
        end
    end

    // Flags are only honoured while idle; anything seen during a sequence is dropped.
    assign take_exc      = (state == IDLE) && (flag_cause != CAUSE_NONE);
    assign mem_read_last = (state == MEM_READ) && (wait_cnt == 3'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode from the registered state.
    always_comb begin
        state_next   = state;
        mem_addr_sel = 3'b000;
        epc_write    = 1'b0;
        pc_write     = 1'b0;
        busy         = 1'b0;
        exc_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (take_exc) begin
                    state_next = SAVE_EPC;
                end
            end
            SAVE_EPC: begin
                busy       = 1'b1;
                epc_write  = 1'b1;
                state_next = MEM_READ;
            end
            MEM_READ: begin
                busy = 1'b1;
                unique case (exc_cause)
                    CAUSE_INVALID: mem_addr_sel = 3'b100;
                    CAUSE_OVF:     mem_addr_sel = 3'b101;
                    CAUSE_DIVZERO: mem_addr_sel = 3'b110;
                    default:       mem_addr_sel = 3'b000;
                endcase
                if (wait_cnt == 3'd0) begin
                    state_next = LOAD_PC;
                end
            end
            LOAD_PC: begin
                busy     = 1'b1;
                pc_write = 1'b1;
                exc_done = 1'b1;
                unique case (exc_cause)
                    CAUSE_INVALID: mem_addr_sel = 3'b100;
                    CAUSE_OVF:     mem_addr_sel = 3'b101;
                    CAUSE_DIVZERO: mem_addr_sel = 3'b110;
                    default:       mem_addr_sel = 3'b000;
                endcase
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory wait counter: loaded with MEM_LAT-1 as MEM_READ is entered, counts down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 3'd0;
        end else if (state == SAVE_EPC) begin
            wait_cnt <= 3'(MEM_LAT - 1);
        end else if ((state == MEM_READ) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Cause and faulting PC are captured on the detection edge; the PC is kept
    // already offset-corrected so EPC is valid throughout SAVE_EPC and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cause <= CAUSE_NONE;
            epc_value <= 32'd0;
        end else if (take_exc) begin
            exc_cause <= flag_cause;
            epc_value <= pc_current - 32'(PC_OFFSET);
        end
    end

    // Handler byte captured when the read data becomes valid, so it is stable
    // during LOAD_PC and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_value <= 32'd0;
        end else if (mem_read_last) begin
            pc_value <= {24'd0, mem_data_out[7:0]};
        end
    end

`ifdef EXC_COUNT_EN
    // Saturating count of completed sequences, bumped on the LOAD_PC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_count <= 8'd0;
        end else if ((state == LOAD_PC) && (exc_count != 8'hFF)) begin
            exc_count <= exc_count + 8'd1;
        end
    end
`endif

endmodule
